// File: rtl/issue_queue_pkg.sv
// Shared LC-3b types for the issue queue: opcodes, dispatch classes, bus structs
// and queue-entry layout. The bus structs are fixed to DATA_WIDTH/TAG_WIDTH.
package issue_queue_pkg;

    localparam int IQ_DEPTH      = 4;
    localparam int IQ_NUM_ALU_RS = 3;
    localparam int DATA_WIDTH    = 16;
    localparam int TAG_WIDTH     = 3;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB = 4'h3,
        OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
        OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
        OP_JMP  = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
    } opcode_t;

    // Which resource an instruction needs besides a ROB slot.
    typedef enum logic [1:0] {CLS_ALU, CLS_MEM, CLS_ROB, CLS_HOLD} op_class_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        predict;
    } iq_entry_t;

    typedef struct packed {
        logic                  busy;
        logic [TAG_WIDTH-1:0]  rob_entry;
        logic [DATA_WIDTH-1:0] value;
    } regfile_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_t;

    function automatic op_class_t op_class(input opcode_t op);
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_SHF: return CLS_ALU;
            OP_LDR, OP_STR:                 return CLS_MEM;
            OP_BR, OP_LEA:                  return CLS_ROB;
            default:                        return CLS_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side bus of the issue queue: instruction handshake plus the
// predicted-taken redirect travelling back to fetch.
interface issue_queue_if;

    logic        fetch_valid;
    logic [15:0] fetch_instr;
    logic [15:0] fetch_pc;
    logic        fetch_predict;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    modport master (
        output fetch_valid, fetch_instr, fetch_pc, fetch_predict,
        input  fetch_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, fetch_predict,
        output fetch_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/issue_queue_operand_resolve.sv
// One operand source mux: regfile value, then CDB bypass, then ROB forward,
// otherwise the pending ROB tag with ready low.
module operand_resolve
    import issue_queue_pkg::*;
(
    input  regfile_t              i_reg,
    input  cdb_t                  i_cdb,
    input  logic [DATA_WIDTH-1:0] i_rob_value,
    input  logic                  i_rob_valid,
    output logic [DATA_WIDTH-1:0] o_value,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic                  o_ready
);

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path through the ifs can infer a latch.
        o_value = '0;
        o_tag   = '0;
        o_ready = 1'b0;
        if (!i_reg.busy) begin
            o_value = i_reg.value;
            o_ready = 1'b1;
        end else if (i_cdb.valid && (i_cdb.tag == i_reg.rob_entry)) begin
            o_value = i_cdb.data;
            o_ready = 1'b1;
        end else if (i_rob_valid) begin
            o_value = i_rob_value;
            o_ready = 1'b1;
        end else begin
            o_tag = i_reg.rob_entry;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order DEPTH-entry instruction queue between fetch and dispatch; issues the
// head to ALU stations, load/store buffer and ROB, and redirects on taken branches.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH      = IQ_DEPTH,
    parameter int NUM_ALU_RS = IQ_NUM_ALU_RS,
    parameter int data_width = DATA_WIDTH,
    parameter int tag_width  = TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    issue_queue_if.slave          fetch,
    input  logic                  flush,
    input  cdb_t                  CDB_in,
    input  logic [NUM_ALU_RS-1:0] alu_rs_busy,
    input  logic                  ldstr_full,
    input  logic                  rob_full,
    input  logic [tag_width-1:0]  rob_addr,
    input  logic [data_width-1:0] rob_sr1_value,
    input  logic [data_width-1:0] rob_sr2_value,
    input  logic                  rob_sr1_valid,
    input  logic                  rob_sr2_valid,
    output logic [tag_width-1:0]  rob_sr1_read_addr,
    output logic [tag_width-1:0]  rob_sr2_read_addr,
    input  regfile_t              sr1_in,
    input  regfile_t              sr2_in,
    input  regfile_t              dest_in,
    output logic [2:0]            sr1,
    output logic [2:0]            sr2,
    output logic [2:0]            reg_dest,
    output logic                  ld_reg_busy_dest,
    output logic [tag_width-1:0]  reg_rob_entry,
    output logic [NUM_ALU_RS-1:0] rs_write,
    output opcode_t               res_op,
    output logic [data_width-1:0] res_Vj,
    output logic [data_width-1:0] res_Vk,
    output logic [tag_width-1:0]  res_Qj,
    output logic [tag_width-1:0]  res_Qk,
    output logic                  res_Qj_valid,
    output logic                  res_Qk_valid,
    output logic [tag_width-1:0]  res_dest,
    output logic                  ldstr_write_enable,
    output logic [15:0]           ldstr_offset,
    output logic [15:0]           ldstr_Vbase,
    output logic [15:0]           ldstr_Vsrc,
    output logic [tag_width-1:0]  ldstr_Qbase,
    output logic [tag_width-1:0]  ldstr_Qsrc,
    output logic [tag_width-1:0]  ldstr_dest,
    output logic                  ldstr_Vbase_valid,
    output logic                  ldstr_Vsrc_valid,
    output logic                  rob_write_enable,
    output opcode_t               rob_opcode,
    output logic [2:0]            rob_dest,
    output logic [data_width-1:0] rob_value_in
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    iq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;

    iq_entry_t             w_head;
    opcode_t               w_op;
    op_class_t             w_class;
    logic                  w_head_valid, w_kill, w_res_ok, w_dispatch, w_redirect, w_enq;
    logic                  w_k_imm, w_is_str, w_is_ldr;
    logic [15:0]           w_sext5, w_adj6, w_adj9, w_target;
    logic [NUM_ALU_RS-1:0] w_free, w_lowest;
    logic [data_width-1:0] w_j_val, w_k_val, w_base_val, w_src_val;
    logic [tag_width-1:0]  w_j_tag, w_k_tag, w_base_tag, w_src_tag;
    logic                  w_j_rdy, w_k_rdy, w_base_rdy, w_src_rdy;

    assign w_head       = r_mem[r_head];
    assign w_head_valid = (r_count != '0);
    assign w_op         = opcode_t'(w_head.instr[15:12]);
    assign w_class      = op_class(w_op);
    assign w_is_str     = (w_op == OP_STR);
    assign w_is_ldr     = (w_op == OP_LDR);
    assign w_sext5      = {{11{w_head.instr[4]}}, w_head.instr[4:0]};
    assign w_adj6       = {{9{w_head.instr[5]}}, w_head.instr[5:0], 1'b0};
    assign w_adj9       = {{6{w_head.instr[8]}}, w_head.instr[8:0], 1'b0};
    assign w_target     = w_head.pc + w_adj9;
    assign w_k_imm      = (((w_op == OP_ADD) || (w_op == OP_AND)) && w_head.instr[5])
                        || (w_op == OP_SHF);

    // Lowest free station: isolate the least significant set bit of ~busy.
    assign w_free   = ~alu_rs_busy;
    assign w_lowest = w_free & (~w_free + NUM_ALU_RS'(1));

    always_comb begin
        w_res_ok = 1'b0;
        case (w_class)
            CLS_ALU: w_res_ok = |w_free;
            CLS_MEM: w_res_ok = !ldstr_full;
            CLS_ROB: w_res_ok = 1'b1;
            default: w_res_ok = 1'b0;
        endcase
    end

    assign w_kill     = flush || reset;
    assign w_dispatch = w_head_valid && !w_kill && !rob_full && w_res_ok;
    assign w_redirect = w_dispatch && (w_op == OP_BR) && w_head.predict;
    assign w_enq      = fetch.fetch_valid && fetch.fetch_ready && !w_kill && !w_redirect;

    assign fetch.fetch_ready    = (r_count != FULL_COUNT);
    assign fetch.redirect_valid = w_redirect;
    assign fetch.redirect_pc    = w_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_tail  <= r_head;
            r_count <= '0;
        end else if (w_redirect) begin
            // Taken branch leaves; everything younger is squashed.
            r_head  <= r_head + PTR_W'(1);
            r_tail  <= r_head + PTR_W'(1);
            r_count <= '0;
        end else begin
            if (w_enq)      r_tail <= r_tail + PTR_W'(1);
            if (w_dispatch) r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_dispatch);
        end
    end

    // NOTE: queue storage has no reset; validity comes from r_count alone.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= '{instr: fetch.fetch_instr, pc: fetch.fetch_pc,
                                      predict: fetch.fetch_predict};
    end

    operand_resolve u_j (
        .i_reg(sr1_in), .i_cdb(CDB_in), .i_rob_value(rob_sr1_value), .i_rob_valid(rob_sr1_valid),
        .o_value(w_j_val), .o_tag(w_j_tag), .o_ready(w_j_rdy)
    );
    operand_resolve u_k (
        .i_reg(sr2_in), .i_cdb(CDB_in), .i_rob_value(rob_sr2_value), .i_rob_valid(rob_sr2_valid),
        .o_value(w_k_val), .o_tag(w_k_tag), .o_ready(w_k_rdy)
    );
    operand_resolve u_base (
        .i_reg(sr1_in), .i_cdb(CDB_in), .i_rob_value(rob_sr1_value), .i_rob_valid(rob_sr1_valid),
        .o_value(w_base_val), .o_tag(w_base_tag), .o_ready(w_base_rdy)
    );
    operand_resolve u_src (
        .i_reg(dest_in), .i_cdb(CDB_in), .i_rob_value(rob_sr2_value), .i_rob_valid(rob_sr2_valid),
        .o_value(w_src_val), .o_tag(w_src_tag), .o_ready(w_src_rdy)
    );

    // STR's stored register lives in the dest field, so ROB port 2 follows it.
    assign rob_sr1_read_addr = sr1_in.rob_entry;
    assign rob_sr2_read_addr = w_is_str ? dest_in.rob_entry : sr2_in.rob_entry;
    assign sr1               = w_head.instr[8:6];
    assign sr2               = w_head.instr[2:0];
    assign reg_dest          = w_head.instr[11:9];
    assign reg_rob_entry     = rob_addr;

    assign res_op       = w_op;
    assign res_Vj       = w_j_val;
    assign res_Qj       = w_j_tag;
    assign res_Qj_valid = !w_j_rdy;
    assign res_Vk       = w_k_imm ? w_sext5 : w_k_val;
    assign res_Qk       = w_k_imm ? '0 : w_k_tag;
    assign res_Qk_valid = !w_k_imm && !w_k_rdy;
    assign res_dest     = rob_addr;

    assign ldstr_offset      = w_adj6;
    assign ldstr_Vbase       = w_base_val;
    assign ldstr_Qbase       = w_base_tag;
    assign ldstr_Vbase_valid = w_base_rdy;
    assign ldstr_Vsrc        = w_is_str ? w_src_val : '0;
    assign ldstr_Qsrc        = w_is_str ? w_src_tag : '0;
    assign ldstr_Vsrc_valid  = w_is_str && w_src_rdy;
    assign ldstr_dest        = w_is_ldr ? rob_addr : '0;

    assign rob_opcode = w_op;
    assign rob_dest   = w_head.instr[11:9];

    always_comb begin
        rob_value_in = '0;
        if (w_op == OP_LEA)     rob_value_in = w_target;
        else if (w_op == OP_BR) rob_value_in = w_head.predict ? w_head.pc : w_target;
    end

    always_comb begin
        rs_write           = '0;
        rob_write_enable   = 1'b0;
        ldstr_write_enable = 1'b0;
        ld_reg_busy_dest   = 1'b0;
        if (w_dispatch) begin
            case (w_class)
                CLS_ALU: begin
                    rs_write         = w_lowest;
                    rob_write_enable = 1'b1;
                    ld_reg_busy_dest = 1'b1;
                end
                CLS_MEM: begin
                    ldstr_write_enable = 1'b1;
                    rob_write_enable   = w_is_ldr;
                    ld_reg_busy_dest   = w_is_ldr;
                end
                CLS_ROB: begin
                    rob_write_enable = 1'b1;
                    ld_reg_busy_dest = (w_op == OP_LEA);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: stimulus pushes expected dispatches into a
// scoreboard queue; a negedge monitor pops and compares whenever the DUT issues.
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, flush, ldstr_full, rob_full;
    cdb_t           cdb;
    logic [2:0]     alu_rs_busy, rob_addr;
    logic [15:0]    rob_sr1_value, rob_sr2_value;
    logic           rob_sr1_valid, rob_sr2_valid;
    regfile_t       sr1_in, sr2_in, dest_in;
    logic [2:0]     rob_sr1_read_addr, rob_sr2_read_addr, sr1, sr2, reg_dest, reg_rob_entry;
    logic           ld_reg_busy_dest;
    logic [2:0]     rs_write;
    opcode_t        res_op, rob_opcode;
    logic [15:0]    res_Vj, res_Vk, ldstr_offset, ldstr_Vbase, ldstr_Vsrc, rob_value_in;
    logic [2:0]     res_Qj, res_Qk, res_dest, ldstr_Qbase, ldstr_Qsrc, ldstr_dest, rob_dest;
    logic           res_Qj_valid, res_Qk_valid, ldstr_write_enable;
    logic           ldstr_Vbase_valid, ldstr_Vsrc_valid, rob_write_enable;

    issue_queue_if fif ();

    issue_queue dut (
        .clk(clk), .reset(reset), .fetch(fif), .flush(flush), .CDB_in(cdb),
        .alu_rs_busy(alu_rs_busy), .ldstr_full(ldstr_full), .rob_full(rob_full),
        .rob_addr(rob_addr), .rob_sr1_value(rob_sr1_value), .rob_sr2_value(rob_sr2_value),
        .rob_sr1_valid(rob_sr1_valid), .rob_sr2_valid(rob_sr2_valid),
        .rob_sr1_read_addr(rob_sr1_read_addr), .rob_sr2_read_addr(rob_sr2_read_addr),
        .sr1_in(sr1_in), .sr2_in(sr2_in), .dest_in(dest_in),
        .sr1(sr1), .sr2(sr2), .reg_dest(reg_dest), .ld_reg_busy_dest(ld_reg_busy_dest),
        .reg_rob_entry(reg_rob_entry), .rs_write(rs_write), .res_op(res_op),
        .res_Vj(res_Vj), .res_Vk(res_Vk), .res_Qj(res_Qj), .res_Qk(res_Qk),
        .res_Qj_valid(res_Qj_valid), .res_Qk_valid(res_Qk_valid), .res_dest(res_dest),
        .ldstr_write_enable(ldstr_write_enable), .ldstr_offset(ldstr_offset),
        .ldstr_Vbase(ldstr_Vbase), .ldstr_Vsrc(ldstr_Vsrc), .ldstr_Qbase(ldstr_Qbase),
        .ldstr_Qsrc(ldstr_Qsrc), .ldstr_dest(ldstr_dest),
        .ldstr_Vbase_valid(ldstr_Vbase_valid), .ldstr_Vsrc_valid(ldstr_Vsrc_valid),
        .rob_write_enable(rob_write_enable), .rob_opcode(rob_opcode),
        .rob_dest(rob_dest), .rob_value_in(rob_value_in)
    );

    typedef enum {K_ALU, K_STR, K_BR, K_LEA} kind_t;
    typedef struct {
        kind_t       kind;
        logic [2:0]  rs;
        logic [15:0] vj;
        logic        qj_v;
        logic [2:0]  qj;
        logic [15:0] vk;
        logic [15:0] rob_value;
        logic [15:0] redirect_pc;
        logic [15:0] vbase;
        logic [15:0] vsrc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [15:0] instr, input logic [15:0] pc, input logic pred);
        fif.fetch_valid   = 1'b1;
        fif.fetch_instr   = instr;
        fif.fetch_pc      = pc;
        fif.fetch_predict = pred;
        tick();
        fif.fetch_valid = 1'b0;
    endtask

    task automatic push_alu(input logic [2:0] rs, input logic [15:0] vj, input logic qj_v,
                            input logic [2:0] qj, input logic [15:0] vk);
        exp_t x;
        x.kind = K_ALU; x.rs = rs; x.vj = vj; x.qj_v = qj_v; x.qj = qj; x.vk = vk;
        exp_q.push_back(x);
    endtask

    task automatic push_rob(input kind_t k, input logic [15:0] value, input logic [15:0] target);
        exp_t x;
        x.kind = k; x.rob_value = value; x.redirect_pc = target;
        exp_q.push_back(x);
    endtask

    task automatic push_str(input logic [15:0] vbase, input logic [15:0] vsrc);
        exp_t x;
        x.kind = K_STR; x.vbase = vbase; x.vsrc = vsrc;
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor: every issued dispatch must match the oldest expectation.
    always @(negedge clk) begin
        if ((|rs_write) || rob_write_enable || ldstr_write_enable || fif.redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dispatch: rs_write=%b rob_we=%b ldstr_we=%b redirect=%b, expected none (t=%0t)",
                         rs_write, rob_write_enable, ldstr_write_enable, fif.redirect_valid, $time);
            end else begin
                mon_e = exp_q.pop_front();
                case (mon_e.kind)
                    K_ALU: begin
                        check("alu_rs_write", rs_write, mon_e.rs);
                        check("alu_rob_we", rob_write_enable, 1);
                        check("alu_busy_dest", ld_reg_busy_dest, 1);
                        check("alu_res_dest", res_dest, 4);
                        check("alu_Qj_valid", res_Qj_valid, mon_e.qj_v);
                        if (mon_e.qj_v) check("alu_Qj", res_Qj, mon_e.qj);
                        else            check("alu_Vj", res_Vj, mon_e.vj);
                        check("alu_Vk", res_Vk, mon_e.vk);
                        check("alu_Qk_valid", res_Qk_valid, 0);
                    end
                    K_STR: begin
                        check("str_ldstr_we", ldstr_write_enable, 1);
                        check("str_rob_we", rob_write_enable, 0);
                        check("str_rs_write", rs_write, 0);
                        check("str_Vbase", ldstr_Vbase, mon_e.vbase);
                        check("str_offset", ldstr_offset, 16'h0002);
                        check("str_Vsrc", ldstr_Vsrc, mon_e.vsrc);
                        check("str_Vsrc_valid", ldstr_Vsrc_valid, 1);
                        check("str_dest", ldstr_dest, 0);
                    end
                    K_BR: begin
                        check("br_rob_we", rob_write_enable, 1);
                        check("br_rs_write", rs_write, 0);
                        check("br_redirect_valid", fif.redirect_valid, 1);
                        check("br_redirect_pc", fif.redirect_pc, mon_e.redirect_pc);
                        check("br_rob_value", rob_value_in, mon_e.rob_value);
                    end
                    default: begin
                        check("lea_rob_we", rob_write_enable, 1);
                        check("lea_rs_write", rs_write, 0);
                        check("lea_redirect", fif.redirect_valid, 0);
                        check("lea_rob_opcode", rob_opcode, OP_LEA);
                        check("lea_rob_value", rob_value_in, mon_e.rob_value);
                    end
                endcase
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; ldstr_full = 1'b0; rob_full = 1'b0;
        cdb = '0; alu_rs_busy = 3'b000; rob_addr = 3'd4;
        rob_sr1_value = 16'h0; rob_sr2_value = 16'h0;
        rob_sr1_valid = 1'b0; rob_sr2_valid = 1'b0;
        sr1_in  = {1'b0, 3'd0, 16'h1111};
        sr2_in  = {1'b0, 3'd0, 16'h2222};
        dest_in = {1'b0, 3'd0, 16'h3333};
        fif.fetch_valid = 1'b0; fif.fetch_instr = '0; fif.fetch_pc = '0; fif.fetch_predict = 1'b0;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_fetch_ready", fif.fetch_ready, 1);
        check("reset_rs_write", rs_write, 0);
        check("reset_rob_we", rob_write_enable, 0);
        check("reset_ldstr_we", ldstr_write_enable, 0);
        check("reset_busy_dest", ld_reg_busy_dest, 0);
        check("reset_redirect", fif.redirect_valid, 0);

        // Fill the queue while every ALU station is busy.
        alu_rs_busy = 3'b111;
        enq(16'h1283, 16'h3000, 1'b0);
        enq(16'h1283, 16'h3002, 1'b0);
        enq(16'h12BD, 16'h3004, 1'b0);
        check("ready_at_count3", fif.fetch_ready, 1);
        enq(16'h1283, 16'h3006, 1'b0);
        check("ready_at_full", fif.fetch_ready, 0);
        tick();
        check("ready_held_full", fif.fetch_ready, 0);

        // Station 1 frees: regfile operands, one-hot 010.
        push_alu(3'b010, 16'h1111, 1'b0, 3'd0, 16'h2222);
        alu_rs_busy = 3'b101;
        tick();
        alu_rs_busy = 3'b111;
        check("ready_after_pop", fif.fetch_ready, 1);

        // R2 busy on tag 5, CDB broadcasting tag 5.
        sr1_in = {1'b1, 3'd5, 16'h0000};
        cdb    = {1'b1, 3'd5, 16'h1234};
        push_alu(3'b001, 16'h1234, 1'b0, 3'd0, 16'h2222);
        alu_rs_busy = 3'b110;
        tick();
        alu_rs_busy = 3'b111;

        // CDB idle, ROB not ready: tag 5 pending; immediate -3 on Vk.
        cdb = '0;
        push_alu(3'b001, 16'h0000, 1'b1, 3'd5, 16'hFFFD);
        alu_rs_busy = 3'b110;
        #1 check("rob_sr1_read_addr", rob_sr1_read_addr, 3'd5);
        tick();
        alu_rs_busy = 3'b111;

        // ROB forward supplies the value; only station 2 free.
        rob_sr1_valid = 1'b1; rob_sr1_value = 16'hCAFE;
        push_alu(3'b100, 16'hCAFE, 1'b0, 3'd0, 16'h2222);
        alu_rs_busy = 3'b011;
        tick();
        alu_rs_busy = 3'b000;
        rob_sr1_valid = 1'b0;
        sr1_in = {1'b0, 3'd0, 16'h1111};
        tick();

        // Predicted-taken BR with two younger entries; same-cycle enqueue dropped.
        rob_full = 1'b1;
        enq(16'h0E02, 16'h3002, 1'b1);
        enq(16'h1283, 16'h3004, 1'b0);
        enq(16'h1283, 16'h3006, 1'b0);
        push_rob(K_BR, 16'h3002, 16'h3006);
        rob_full = 1'b0;
        fif.fetch_valid = 1'b1; fif.fetch_instr = 16'h1283; fif.fetch_pc = 16'h3008;
        fif.fetch_predict = 1'b0;
        tick();
        fif.fetch_valid = 1'b0;
        check("redirect_one_cycle", fif.redirect_valid, 0);
        check("ready_after_squash", fif.fetch_ready, 1);
        repeat (3) tick();

        // STR: base ready, stored register resolved via ROB forward.
        sr1_in  = {1'b0, 3'd0, 16'h4000};
        dest_in = {1'b1, 3'd2, 16'h0000};
        rob_sr2_valid = 1'b1; rob_sr2_value = 16'hBEEF;
        push_str(16'h4000, 16'hBEEF);
        enq(16'h7941, 16'h3020, 1'b0);
        check("str_rob_sr2_read_addr", rob_sr2_read_addr, 3'd2);
        check("str_no_busy_dest", ld_reg_busy_dest, 0);
        tick();
        dest_in = {1'b0, 3'd0, 16'h3333};
        sr1_in  = {1'b0, 3'd0, 16'h1111};
        rob_sr2_valid = 1'b0;

        // Flush against a dispatchable head and a concurrent fetch.
        rob_full = 1'b1;
        enq(16'h1283, 16'h3030, 1'b0);
        rob_full = 1'b0; flush = 1'b1;
        fif.fetch_valid = 1'b1; fif.fetch_instr = 16'h1283; fif.fetch_pc = 16'h3032;
        #1;
        check("flush_rs_write", rs_write, 0);
        check("flush_rob_we", rob_write_enable, 0);
        tick();
        flush = 1'b0; fif.fetch_valid = 1'b0;
        check("flush_ready", fif.fetch_ready, 1);
        repeat (3) tick();

        // LEA held by rob_full for three cycles, then issues.
        rob_full = 1'b1;
        enq(16'hEC03, 16'h3010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("lea_stall_rob_we", rob_write_enable, 0);
            check("lea_stall_head", rob_opcode, OP_LEA);
            tick();
        end
        push_rob(K_LEA, 16'h3016, 16'h0000);
        rob_full = 1'b0;
        tick();

        // JMP parks at the head until flush; queue usable afterwards.
        enq(16'hC1C0, 16'h3050, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("jmp_hold_rob_we", rob_write_enable, 0);
            check("jmp_hold_rs_write", rs_write, 0);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push_rob(K_LEA, 16'h3046, 16'h0000);
        enq(16'hEC03, 16'h3040, 1'b0);
        repeat (3) tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
